// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine: coin encodings, coin values and FSM states.
package vending_pkg;

    localparam logic [1:0] COIN_NONE    = 2'd0;
    localparam logic [1:0] COIN_NICKEL  = 2'd1;
    localparam logic [1:0] COIN_DIME    = 2'd2;
    localparam logic [1:0] COIN_QUARTER = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DISPENSE,
        ST_REFUND
    } state_t;

    // Value of a coin in nickel units.
    function automatic logic [2:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_NICKEL:  return 3'd1;
            COIN_DIME:    return 3'd2;
            COIN_QUARTER: return 3'd5;
            default:      return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vending_machine_param.sv
// Parameterised vending machine: accumulates coins, dispenses at PRICE with change,
// refunds on cancel, and keeps a saturating sales count. All outputs are registered.
module vending_machine_param
    import vending_pkg::*;
#(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 6,
    parameter int COUNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                valid,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [COUNT_W-1:0]  sales
);

    localparam logic [CREDIT_W-1:0] PRICE_U = CREDIT_W'(PRICE);

    state_t              r_state;
    state_t              w_next_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_next_credit;
    logic [CREDIT_W-1:0] r_change;
    logic [CREDIT_W-1:0] w_next_change;
    logic                r_valid;
    logic                w_next_valid;
    logic                r_change_valid;
    logic                w_next_change_valid;
    logic                r_coin_reject;
    logic                w_next_coin_reject;
    logic                w_sale;
    logic [CREDIT_W-1:0] w_total;

    // PRICE is bounded so that credit + largest coin always fits in CREDIT_W bits.
    assign w_total = r_credit + CREDIT_W'(coin_value(coin));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_change       <= '0;
            r_valid        <= 1'b0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_credit       <= w_next_credit;
            r_change       <= w_next_change;
            r_valid        <= w_next_valid;
            r_change_valid <= w_next_change_valid;
            r_coin_reject  <= w_next_coin_reject;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_next_state        = ST_IDLE;
        w_next_credit       = r_credit;
        w_next_change       = '0;
        w_next_valid        = 1'b0;
        w_next_change_valid = 1'b0;
        w_next_coin_reject  = 1'b0;
        w_sale              = 1'b0;

        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (w_total == '0) begin
                    w_next_state = ST_IDLE;
                end else if (cancel) begin
                    w_next_state        = ST_REFUND;
                    w_next_change       = w_total;
                    w_next_change_valid = 1'b1;
                    w_next_credit       = '0;
                end else if (w_total >= PRICE_U) begin
                    w_next_state        = ST_DISPENSE;
                    w_next_change       = w_total - PRICE_U;
                    w_next_change_valid = (w_total != PRICE_U);
                    w_next_valid        = 1'b1;
                    w_next_credit       = '0;
                    w_sale              = 1'b1;
                end else begin
                    w_next_state  = ST_COLLECT;
                    w_next_credit = w_total;
                end
            end
            default: begin
                // One-cycle DISPENSE/REFUND: coins are bounced back and cancel is ignored.
                w_next_state       = ST_IDLE;
                w_next_credit      = '0;
                w_next_coin_reject = (coin != COIN_NONE);
            end
        endcase
    end

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_sales (
        .clk     (clk),
        .rst_n   (reset),
        .i_inc   (w_sale),
        .o_count (sales)
    );

    assign valid        = r_valid;
    assign change       = r_change;
    assign change_valid = r_change_valid;
    assign coin_reject  = r_coin_reject;
    assign credit       = r_credit;

endmodule

// File: tb/tb_vending_machine_param.sv
// Self-checking bench: directed scenarios plus randomized coins/cancel/reset
// compared against a transaction-level model of the vending rules.
module tb_vending_machine_param;

    localparam int PRICE     = 4;
    localparam int CREDIT_W  = 6;
    localparam int COUNT_W   = 2;
    localparam int SALES_MAX = (1 << COUNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          coin;
    logic                cancel;
    logic                valid;
    logic [CREDIT_W-1:0] change;
    logic                change_valid;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic [COUNT_W-1:0]  sales;

    vending_machine_param #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin         (coin),
        .cancel       (cancel),
        .valid        (valid),
        .change       (change),
        .change_valid (change_valid),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .sales        (sales)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: credit held so far, whether the previous edge completed a
    // sale/refund (machine busy for one cycle), and the outputs that edge produces.
    int m_credit;
    int m_sales;
    bit m_busy;
    int e_valid, e_change, e_cv, e_reject;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int units(input int c);
        case (c)
            1:       return 1;
            2:       return 2;
            3:       return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_credit = 0; m_sales = 0; m_busy = 0;
        e_valid = 0; e_change = 0; e_cv = 0; e_reject = 0;
    endtask

    task automatic model_edge(input int c, input bit cn);
        int total;
        e_valid = 0; e_change = 0; e_cv = 0; e_reject = 0;
        if (m_busy) begin
            e_reject = (c != 0);
            m_busy   = 0;
        end else begin
            total = m_credit + units(c);
            if (total > 0 && cn) begin
                e_change = total; e_cv = 1; m_credit = 0; m_busy = 1;
            end else if (total >= PRICE) begin
                e_valid  = 1;
                e_change = total - PRICE;
                e_cv     = (e_change > 0);
                m_credit = 0;
                m_busy   = 1;
                if (m_sales < SALES_MAX) m_sales++;
            end else begin
                m_credit = total;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_credit"}, 32'(credit), m_credit);
        check({tag, "_valid"}, 32'(valid), e_valid);
        check({tag, "_change"}, 32'(change), e_change);
        check({tag, "_cv"}, 32'(change_valid), e_cv);
        check({tag, "_reject"}, 32'(coin_reject), e_reject);
        check({tag, "_sales"}, 32'(sales), m_sales);
    endtask

    // Present inputs, take one rising edge, then compare just after it.
    task automatic step(input int c, input bit cn, input string tag);
        coin   = 2'(c);
        cancel = cn;
        @(posedge clk);
        #1;
        model_edge(c, cn);
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges, released before the next edge.
    task automatic apply_reset(input string tag);
        coin   = 2'd0;
        cancel = 1'b0;
        reset  = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        coin   = 2'd0;
        cancel = 1'b0;
        #1;
        model_reset();
        check_all("por");
        repeat (2) @(posedge clk);
        #1;
        check_all("por_hold");
        @(negedge clk);
        reset = 1'b1;

        // Nickels every cycle: 1,2,3 then a sale with no change.
        step(1, 0, "n1"); check("n1_credit_k", 32'(credit), 1);
        step(1, 0, "n2"); check("n2_credit_k", 32'(credit), 2);
        step(1, 0, "n3"); check("n3_credit_k", 32'(credit), 3);
        step(1, 0, "n4");
        check("n4_valid_k", 32'(valid), 1);
        check("n4_cv_k", 32'(change_valid), 0);
        check("n4_sales_k", 32'(sales), 1);
        step(0, 0, "n5");

        // Credit 3 then a quarter: change 4.
        step(1, 0, "q1"); step(1, 0, "q2"); step(1, 0, "q3");
        step(3, 0, "q4");
        check("q4_valid_k", 32'(valid), 1);
        check("q4_change_k", 32'(change), 4);
        check("q4_cv_k", 32'(change_valid), 1);
        check("q4_credit_k", 32'(credit), 0);
        step(0, 0, "q5");

        // Credit 2 then nickel together with cancel: refund of 3.
        step(2, 0, "c1");
        step(1, 1, "c2");
        check("c2_change_k", 32'(change), 3);
        check("c2_cv_k", 32'(change_valid), 1);
        check("c2_valid_k", 32'(valid), 0);
        check("c2_sales_k", 32'(sales), 2);
        step(0, 1, "c3");
        step(0, 1, "c4_cancel_empty");

        // Dime during DISPENSE is bounced for exactly one cycle.
        step(3, 0, "r1");
        step(2, 0, "r2");
        check("r2_reject_k", 32'(coin_reject), 1);
        check("r2_credit_k", 32'(credit), 0);
        step(0, 0, "r3");
        check("r3_reject_k", 32'(coin_reject), 0);

        // Saturation of the 2-bit sales counter over five sales.
        apply_reset("sat_rst");
        for (int i = 0; i < 5; i++) begin
            step(3, 0, $sformatf("sat%0d", i));
            check($sformatf("sat%0d_sales_k", i), 32'(sales), (i < 3) ? i + 1 : 3);
            step(0, 0, $sformatf("sat%0d_idle", i));
        end

        // Asynchronous reset between edges with credit 3.
        step(1, 0, "a1"); step(1, 0, "a2"); step(1, 0, "a3");
        #2;
        reset = 1'b0;
        #1;
        check("a_credit_k", 32'(credit), 0);
        check("a_valid_k", 32'(valid), 0);
        check("a_change_k", 32'(change), 0);
        check("a_cv_k", 32'(change_valid), 0);
        check("a_reject_k", 32'(coin_reject), 0);
        check("a_sales_k", 32'(sales), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1, 0, "a4");
        check("a4_credit_k", 32'(credit), 1);

        // Reset in the middle of a DISPENSE cycle aborts it.
        step(3, 0, "d1");
        apply_reset("d_abort");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                apply_reset("rnd_rst");
            end else begin
                step(int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vending_machine_param.md
VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 Parameter PRICE, default 4: item price in nickel units; legal range 1 .. 2**CREDIT_W-6.
REQ-002 Parameter CREDIT_W, default 6: width of credit and change.
REQ-003 Parameter COUNT_W, default 8: width of the sales counter.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 coin  input  2: coin inserted this cycle; 0 none, 1 nickel (1 unit), 2 dime (2 units), 3 quarter (5 units).
REQ-007 cancel  input  1: request refund of accumulated credit.
REQ-008 valid  output  1: dispense pulse, one cycle per sale.
REQ-009 change  output  CREDIT_W: change or refund amount in units; zero when change_valid is low.
REQ-010 change_valid  output  1: change is meaningful this cycle.
REQ-011 coin_reject  output  1: coin sampled last edge was returned, not credited.
REQ-012 credit  output  CREDIT_W: current accumulated credit.
REQ-013 sales  output  COUNT_W: saturating count of completed sales.

Function
REQ-014 FSM states: IDLE (credit 0), COLLECT (0 < credit < PRICE), DISPENSE, REFUND; all outputs registered.
REQ-015 Per edge, total = credit + value(coin); coin value taken only in IDLE/COLLECT.
REQ-016 IDLE/COLLECT, cancel=0, total >= PRICE -> DISPENSE; change register = total - PRICE; credit <= 0.
REQ-017 IDLE/COLLECT, cancel=0, 0 < total < PRICE -> COLLECT; credit <= total.
REQ-018 IDLE/COLLECT, cancel=0, total = 0 -> stay IDLE.
REQ-019 IDLE/COLLECT, cancel=1, total > 0 -> REFUND; change register = total; credit <= 0.
REQ-020 Coin arriving in the same cycle as cancel is included in the refund.
REQ-021 cancel with total = 0 has no effect.
REQ-022 Latency: valid is high in the cycle after the edge at which total reaches PRICE.
REQ-023 DISPENSE lasts exactly one cycle: valid=1; change_valid=1 iff change > 0; then -> IDLE.
REQ-024 REFUND lasts exactly one cycle: valid=0, change_valid=1; then -> IDLE.
REQ-025 A coin or cancel presented in DISPENSE or REFUND is not credited.
REQ-026 A rejected coin raises coin_reject for exactly one cycle, the following cycle.
REQ-027 cancel presented in DISPENSE or REFUND is ignored.
REQ-028 sales increments on entry to DISPENSE and saturates at 2**COUNT_W-1; no wrap.
REQ-029 Arithmetic is unsigned, CREDIT_W bits; the PRICE range in REQ-001 guarantees total never overflows.

Reset
REQ-030 reset low asynchronously forces state IDLE and clears credit, change, sales, valid, change_valid and coin_reject to 0.
REQ-031 Reset mid-DISPENSE or mid-REFUND aborts that sale or refund: no pulse, no count.
REQ-032 After reset release, the first credited coin is sampled on the first rising edge with reset high.

Structure
REQ-033 Shared package vending_pkg: coin encodings, coin-value function, FSM state enum.
REQ-034 Single sub-module sat_counter (parametrised width, increment enable, async active-low clear) implements sales.

Verification
REQ-035 PRICE=4, coin=1 every cycle after reset release -> credit 1,2,3; valid=1 in the cycle after the 4th edge, change_valid=0; sales=1.
REQ-036 PRICE=4, credit=3, then coin=3 -> valid=1, change=4, change_valid=1, credit=0 in the same cycle.
REQ-037 PRICE=4, credit=2, then coin=1 with cancel=1 -> REFUND: change=3, change_valid=1, valid=0, sales unchanged.
REQ-038 Coin=2 presented during the DISPENSE cycle -> coin_reject=1 next cycle; credit stays 0.
REQ-039 COUNT_W=2, five sales -> sales reads 3 after the 3rd sale and stays 3.
REQ-040 reset pulsed low between clock edges while credit=3 -> all outputs 0 immediately, state IDLE.
